// File: rtl/conv_feeder.sv
`timescale 1ns/1ps
// Feeds a 3x3 convolution engine from a row-major pixel stream: two line buffers build
// valid-padding windows, each window is issued, its result captured and streamed out.
module conv_feeder #(
    parameter int MAX_W = 64,
    parameter int DW    = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [7:0]      img_w,
    input  logic [7:0]      img_h,
    input  logic            w_load,
    input  logic [9*DW-1:0] w_data,
    input  logic [DW-1:0]   b_data,
    input  logic            px_valid,
    output logic            px_ready,
    input  logic [DW-1:0]   px_data,
    output logic [9*DW-1:0] im,
    output logic [9*DW-1:0] iw,
    output logic [DW-1:0]   ib,
    output logic            conv_ready,
    input  logic            conv_valid,
    input  logic [DW-1:0]   om,
    output logic            eng_rst_n,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [DW-1:0]   res_data,
    output logic            busy,
    output logic            done
);

    localparam int         AW     = $clog2(MAX_W);
    localparam logic [8:0] MAX_W9 = 9'(MAX_W);

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        ISSUE,
        WAIT,
        CLR,
        OUT
    } state_t;

    state_t state, next_state;

    logic [7:0]      width;
    logic [7:0]      height;
    logic [7:0]      row;
    logic [7:0]      col;
    logic            last_px;
    logic            clr_flag;
    logic [DW-1:0]   lb0 [MAX_W];
    logic [DW-1:0]   lb1 [MAX_W];
    logic [DW-1:0]   win [9];
    logic [9*DW-1:0] w_reg;
    logic [DW-1:0]   b_reg;
    logic [DW-1:0]   res_reg;
    logic [AW-1:0]   lb_addr;
    logic            start_ok;
    logic            px_fire;
    logic            win_full;
    logic            at_last;

    assign start_ok = start && (img_w >= 8'd3) && ({1'b0, img_w} <= MAX_W9) && (img_h >= 8'd3);
    assign px_fire  = px_valid && (state == FILL);
    assign win_full = (row >= 8'd2) && (col >= 8'd2);
    assign at_last  = (row == height - 8'd1) && (col == width - 8'd1);
    assign lb_addr  = col[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start_ok) next_state = FILL;
            FILL:    if (px_fire && win_full) next_state = ISSUE;
            ISSUE:   next_state = WAIT;
            WAIT:    if (conv_valid) next_state = CLR;
            CLR:     next_state = OUT;
            OUT:     if (res_ready) next_state = last_px ? IDLE : FILL;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        px_ready   = 1'b0;
        conv_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            IDLE:    busy       = 1'b0;
            FILL:    px_ready   = 1'b1;
            ISSUE:   conv_ready = 1'b1;
            OUT:     res_valid  = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            width    <= '0;
            height   <= '0;
            row      <= '0;
            col      <= '0;
            last_px  <= 1'b0;
            w_reg    <= '0;
            b_reg    <= '0;
            res_reg  <= '0;
            clr_flag <= 1'b0;
            done     <= 1'b0;
        end else begin
            done     <= (state == OUT) && res_ready && last_px;
            // Registered so the engine reset is a clean one-cycle pulse during CLR.
            clr_flag <= (next_state == CLR);
            if (state == IDLE && w_load) begin
                w_reg <= w_data;
                b_reg <= b_data;
            end
            if (state == IDLE && start_ok) begin
                width  <= img_w;
                height <= img_h;
                row    <= '0;
                col    <= '0;
            end
            if (px_fire) begin
                last_px <= at_last;
                if (col == width - 8'd1) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 8'd1;
                end
            end
            if (state == WAIT && conv_valid) begin
                res_reg <= om;
            end
        end
    end

    // Window shifts left; the new right column is {row-2, row-1, current} at this column.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 9; k++) begin
                win[k] <= '0;
            end
        end else if (px_fire) begin
            for (int r = 0; r < 3; r++) begin
                win[3*r]   <= win[3*r+1];
                win[3*r+1] <= win[3*r+2];
            end
            win[2] <= lb0[lb_addr];
            win[5] <= lb1[lb_addr];
            win[8] <= px_data;
        end
    end

    always_ff @(posedge clk) begin
        if (px_fire) begin
            lb0[lb_addr] <= lb1[lb_addr];
            lb1[lb_addr] <= px_data;
        end
    end

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign im[DW*k +: DW] = win[k];
    end

    assign iw        = w_reg;
    assign ib        = b_reg;
    assign res_data  = res_reg;
    assign eng_rst_n = rst_n & ~clr_flag;

endmodule

// File: tb/tb_conv_feeder.sv
`timescale 1ns/1ps
// Randomized bench for conv_feeder: an image-level reference model predicts every window
// and result, while a behavioural engine answers each issue with a sticky conv_valid.
module tb_conv_feeder;

    localparam int MAX_W = 64;
    localparam int DW    = 16;

    typedef logic [9*DW-1:0] wide_t;

    logic            clk        = 1'b0;
    logic            rst_n      = 1'b0;
    logic            start      = 1'b0;
    logic [7:0]      img_w      = '0;
    logic [7:0]      img_h      = '0;
    logic            w_load     = 1'b0;
    logic [9*DW-1:0] w_data     = '0;
    logic [DW-1:0]   b_data     = '0;
    logic            px_valid   = 1'b0;
    logic            px_ready;
    logic [DW-1:0]   px_data    = '0;
    logic [9*DW-1:0] im;
    logic [9*DW-1:0] iw;
    logic [DW-1:0]   ib;
    logic            conv_ready;
    logic            conv_valid = 1'b0;
    logic [DW-1:0]   om         = '0;
    logic            eng_rst_n;
    logic            res_valid;
    logic            res_ready  = 1'b0;
    logic [DW-1:0]   res_data;
    logic            busy;
    logic            done;

    int compared   = 0;
    int mismatched = 0;

    int            eng_lat       = 1;
    logic          eng_fixed     = 1'b0;
    logic [DW-1:0] eng_fixed_val = '0;
    int            eng_cnt       = 0;
    wide_t         eng_win       = '0;

    logic [DW-1:0] img     [0:1023];
    wide_t         exp_win [0:1023];
    logic [DW-1:0] exp_res [0:1023];

    conv_feeder #(.MAX_W(MAX_W), .DW(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .img_w      (img_w),
        .img_h      (img_h),
        .w_load     (w_load),
        .w_data     (w_data),
        .b_data     (b_data),
        .px_valid   (px_valid),
        .px_ready   (px_ready),
        .px_data    (px_data),
        .im         (im),
        .iw         (iw),
        .ib         (ib),
        .conv_ready (conv_ready),
        .conv_valid (conv_valid),
        .om         (om),
        .eng_rst_n  (eng_rst_n),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] engine_result(input wide_t window);
        logic [DW-1:0] acc;
        acc = '0;
        if (eng_fixed) return eng_fixed_val;
        for (int k = 0; k < 9; k++) acc += window[DW*k +: DW];
        return acc ^ 16'h5A5A;
    endfunction

    // Engine keeps conv_valid high until its local reset, like the sticky hardware engine.
    always @(posedge clk or negedge eng_rst_n) begin
        if (!eng_rst_n) begin
            conv_valid <= 1'b0;
            om         <= '0;
            eng_cnt    <= 0;
        end else if (conv_ready) begin
            eng_win <= im;
            if (eng_lat <= 1) begin
                conv_valid <= 1'b1;
                om         <= engine_result(im);
            end else begin
                eng_cnt <= eng_lat - 1;
            end
        end else if (eng_cnt > 0) begin
            eng_cnt <= eng_cnt - 1;
            if (eng_cnt == 1) begin
                conv_valid <= 1'b1;
                om         <= engine_result(eng_win);
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input wide_t observed, input wide_t expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic wide_t rand_wide();
        wide_t v;
        for (int k = 0; k < 9; k++) v[DW*k +: DW] = DW'($urandom);
        return v;
    endfunction

    task automatic loadWeights(input wide_t wts, input logic [DW-1:0] bias);
        w_load = 1'b1;
        w_data = wts;
        b_data = bias;
        @(negedge clk);
        w_load = 1'b0;
        checkOutput("iw_loaded", iw, wts);
        checkOutput("ib_loaded", wide_t'(ib), wide_t'(bias));
    endtask

    task automatic applyStimulus(input int w, input int h, input int lat, input bit seq_px,
                                 input bit stall, input bit wload_mid,
                                 input wide_t wts, input logic [DW-1:0] bias);
        int total, nwin, idx, pidx, ridx, iidx, dones, clrs, spurious, stall_left;
        bit awaiting, issue_due, stall_active, stall_done, wload_done, finished;
        total = w * h;
        nwin  = (w - 2) * (h - 2);
        for (int i = 0; i < total; i++) img[i] = seq_px ? DW'(i + 1) : DW'($urandom);
        idx = 0;
        for (int r = 0; r <= h - 3; r++) begin
            for (int c = 0; c <= w - 3; c++) begin
                for (int k = 0; k < 9; k++) exp_win[idx][DW*k +: DW] = img[(r + k / 3) * w + c + k % 3];
                exp_res[idx] = engine_result(exp_win[idx]);
                idx++;
            end
        end

        @(negedge clk);
        loadWeights(wts, bias);
        eng_lat = lat;
        start = 1'b1;
        img_w = 8'(w);
        img_h = 8'(h);
        @(negedge clk);
        start = 1'b0;
        checkOutput("busy_after_start", wide_t'(busy), wide_t'(1));

        pidx = 0; ridx = 0; iidx = 0; dones = 0; clrs = 0; spurious = 0; stall_left = 0;
        awaiting = 0; issue_due = 0; stall_active = 0; stall_done = 0; wload_done = 0; finished = 0;
        for (int cyc = 0; cyc < 20000 && !finished; cyc++) begin
            if (issue_due) begin
                checkOutput("conv_ready_latency", wide_t'(conv_ready), wide_t'(1));
                checkOutput("im_window", im, exp_win[iidx]);
                checkOutput("iw_at_issue", iw, wts);
                checkOutput("ib_at_issue", wide_t'(ib), wide_t'(bias));
                iidx++;
                issue_due = 0;
            end else if (conv_ready) begin
                spurious++;
            end
            if (awaiting) checkOutput("px_ready_blocked", wide_t'(px_ready), wide_t'(0));
            if (!eng_rst_n) clrs++;
            if (done) begin
                dones++;
                checkOutput("done_after_last", wide_t'(ridx), wide_t'(nwin));
                finished = 1;
            end

            w_load = wload_mid && awaiting && !wload_done;
            if (w_load) begin
                w_data     = ~wts;
                b_data     = ~bias;
                wload_done = 1;
            end

            if (stall_active) begin
                checkOutput("stall_res_valid", wide_t'(res_valid), wide_t'(1));
                checkOutput("stall_res_data", wide_t'(res_data), wide_t'(exp_res[ridx]));
                res_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) stall_active = 0;
            end else if (res_valid) begin
                if (ridx < nwin) begin
                    checkOutput("res_data", wide_t'(res_data), wide_t'(exp_res[ridx]));
                    if (stall && !stall_done) begin
                        stall_active = 1;
                        stall_done   = 1;
                        stall_left   = 9;
                        res_ready    = 1'b0;
                    end else begin
                        res_ready = ($urandom_range(0, 3) != 0);
                    end
                    if (res_ready) begin
                        ridx++;
                        awaiting = 0;
                    end
                end else begin
                    spurious++;
                    res_ready = 1'b1;
                end
            end else begin
                res_ready = 1'($urandom_range(0, 1));
            end

            px_valid = (pidx < total) && ($urandom_range(0, 3) != 0);
            if (stall_active) px_valid = (pidx < total);
            px_data = (pidx < total) ? img[pidx] : DW'($urandom);
            if (px_valid && px_ready) begin
                if ((pidx / w) >= 2 && (pidx % w) >= 2) begin
                    awaiting  = 1;
                    issue_due = 1;
                end
                pidx++;
            end
            @(negedge clk);
        end
        px_valid  = 1'b0;
        res_ready = 1'b0;
        w_load    = 1'b0;

        checkOutput("run_finished", wide_t'(finished), wide_t'(1));
        checkOutput("done_single", wide_t'(done), wide_t'(0));
        checkOutput("done_count", wide_t'(dones), wide_t'(1));
        checkOutput("pixels_accepted", wide_t'(pidx), wide_t'(total));
        checkOutput("issue_count", wide_t'(iidx), wide_t'(nwin));
        checkOutput("result_count", wide_t'(ridx), wide_t'(nwin));
        checkOutput("eng_clear_cycles", wide_t'(clrs), wide_t'(nwin));
        checkOutput("spurious_events", wide_t'(spurious), wide_t'(0));
        checkOutput("busy_after_done", wide_t'(busy), wide_t'(0));
        checkOutput("iw_kept", iw, wts);
    endtask

    task automatic badStart(input string tag, input int w, input int h);
        @(negedge clk);
        start = 1'b1;
        img_w = 8'(w);
        img_h = 8'(h);
        @(negedge clk);
        start = 1'b0;
        checkOutput(tag, wide_t'(busy), wide_t'(0));
        @(negedge clk);
        checkOutput({tag, "_px_ready"}, wide_t'(px_ready), wide_t'(0));
    endtask

    initial begin
        int  rw, rh, pidx;
        bit  seen;
        wide_t ones;
        for (int k = 0; k < 9; k++) ones[DW*k +: DW] = 16'h3C00;

        repeat (3) @(negedge clk);
        checkOutput("rst_px_ready", wide_t'(px_ready), wide_t'(0));
        checkOutput("rst_conv_ready", wide_t'(conv_ready), wide_t'(0));
        checkOutput("rst_res_valid", wide_t'(res_valid), wide_t'(0));
        checkOutput("rst_done", wide_t'(done), wide_t'(0));
        checkOutput("rst_busy", wide_t'(busy), wide_t'(0));
        checkOutput("rst_im", im, '0);
        checkOutput("rst_iw", iw, '0);
        checkOutput("rst_ib", wide_t'(ib), '0);
        checkOutput("rst_res_data", wide_t'(res_data), '0);
        checkOutput("rst_eng_rst_n", wide_t'(eng_rst_n), wide_t'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("eng_rst_n_released", wide_t'(eng_rst_n), wide_t'(1));

        $display("[TB] 3x3 image, pixels 1..9, unit weights, fixed engine result");
        eng_fixed     = 1'b1;
        eng_fixed_val = 16'h4A00;
        applyStimulus(3, 3, 3, 1'b1, 1'b0, 1'b0, ones, 16'h0000);
        eng_fixed = 1'b0;

        $display("[TB] 5x4 image with w_load pulsed while busy");
        applyStimulus(5, 4, 2, 1'b0, 1'b0, 1'b1, rand_wide(), DW'($urandom));

        $display("[TB] result backpressure held for 10 cycles");
        applyStimulus(4, 3, 2, 1'b0, 1'b1, 1'b0, rand_wide(), DW'($urandom));

        $display("[TB] sticky engine with 20-cycle latency");
        applyStimulus(4, 4, 20, 1'b0, 1'b0, 1'b0, rand_wide(), DW'($urandom));

        $display("[TB] illegal sizes on start");
        badStart("bad_start_w2", 2, 5);
        badStart("bad_start_w_over", MAX_W + 1, 3);
        badStart("bad_start_h2", 5, 2);

        $display("[TB] full-width image");
        applyStimulus(MAX_W, 3, 1, 1'b0, 1'b0, 1'b0, rand_wide(), DW'($urandom));

        for (int t = 0; t < 4; t++) begin
            rw = $urandom_range(3, 9);
            rh = $urandom_range(3, 6);
            $display("[TB] random image %0dx%0d", rw, rh);
            applyStimulus(rw, rh, $urandom_range(1, 6), 1'b0, 1'b0, t[0], rand_wide(), DW'($urandom));
        end

        $display("[TB] reset asserted while waiting on the engine");
        @(negedge clk);
        loadWeights(ones, 16'h0000);
        eng_lat = 20;
        start   = 1'b1;
        img_w   = 8'd3;
        img_h   = 8'd3;
        @(negedge clk);
        start = 1'b0;
        seen  = 0;
        pidx  = 0;
        for (int cyc = 0; cyc < 60 && !seen; cyc++) begin
            if (conv_ready) seen = 1;
            px_valid = (pidx < 9);
            px_data  = DW'(pidx + 1);
            if (px_valid && px_ready) pidx++;
            @(negedge clk);
        end
        px_valid = 1'b0;
        checkOutput("reset_test_issue_seen", wide_t'(seen), wide_t'(1));
        repeat (3) @(negedge clk);
        checkOutput("reset_test_in_wait", wide_t'(busy), wide_t'(1));
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_px_ready", wide_t'(px_ready), wide_t'(0));
        checkOutput("midrst_conv_ready", wide_t'(conv_ready), wide_t'(0));
        checkOutput("midrst_res_valid", wide_t'(res_valid), wide_t'(0));
        checkOutput("midrst_busy", wide_t'(busy), wide_t'(0));
        checkOutput("midrst_done", wide_t'(done), wide_t'(0));
        checkOutput("midrst_im", im, '0);
        checkOutput("midrst_iw", iw, '0);
        checkOutput("midrst_ib", wide_t'(ib), '0);
        checkOutput("midrst_res_data", wide_t'(res_data), '0);
        checkOutput("midrst_eng_rst_n", wide_t'(eng_rst_n), wide_t'(0));
        @(negedge clk);
        checkOutput("midrst_eng_rst_n_held", wide_t'(eng_rst_n), wide_t'(0));
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("midrst_eng_rst_n_released", wide_t'(eng_rst_n), wide_t'(1));

        eng_fixed     = 1'b1;
        eng_fixed_val = 16'h4A00;
        applyStimulus(3, 3, 3, 1'b1, 1'b0, 1'b0, ones, 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
